// File: rtl/perim_area_pkg.sv
// Shared types, default geometry and helpers for the perimeter/area ROI engine.
package perim_area_pkg;

    localparam int unsigned DEF_H_ACT = 800;
    localparam int unsigned DEF_V_ACT = 600;
    localparam int unsigned DEF_X_W   = 12;
    localparam int unsigned DEF_Y_W   = 12;
    localparam int unsigned DEF_CNT_W = 24;
    localparam int unsigned DEF_SCALE = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } state_t;

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] top;
        top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= top) ? top : v + 32'd1;
    endfunction

endpackage

// File: rtl/perim_area_roi_if.sv
// Pixel stream, ROI programming and per-frame result bundle.
interface perim_area_roi_if
    import perim_area_pkg::*;
#(
    parameter int unsigned X_W   = DEF_X_W,
    parameter int unsigned Y_W   = DEF_Y_W,
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             sof;
    logic             pix_vld;
    logic             edge_bit;
    logic             mask_bit;
    logic [X_W-1:0]   roi_x0;
    logic [X_W-1:0]   roi_x1;
    logic [Y_W-1:0]   roi_y0;
    logic [Y_W-1:0]   roi_y1;
    logic [CNT_W-1:0] perimeter;
    logic [CNT_W-1:0] area;
    logic [CNT_W-1:0] ratio;
    logic [X_W-1:0]   bbox_xmin;
    logic [X_W-1:0]   bbox_xmax;
    logic [Y_W-1:0]   bbox_ymin;
    logic [Y_W-1:0]   bbox_ymax;
    logic             obj_present;
    logic             div_zero;
    logic             res_vld;
    logic             busy;
    logic             overrun;

    modport master (
        output sof, pix_vld, edge_bit, mask_bit, roi_x0, roi_x1, roi_y0, roi_y1,
        input  perimeter, area, ratio, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
        input  obj_present, div_zero, res_vld, busy, overrun
    );

    modport slave (
        input  sof, pix_vld, edge_bit, mask_bit, roi_x0, roi_x1, roi_y0, roi_y1,
        output perimeter, area, ratio, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
        output obj_present, div_zero, res_vld, busy, overrun
    );
endinterface

// File: rtl/perim_area_roi_seq_divider.sv
// W-bit restoring divider, one quotient bit per cycle, done pulses W cycles after start.
module seq_divider #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] numerator,
    input  logic [W-1:0] denominator,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done
);
    localparam int unsigned CW = $clog2(W);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  den_q;
    logic [CW-1:0] cnt_q;
    logic          active_q;

    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r,
                                                input logic [W-1:0] q,
                                                input logic [W-1:0] d);
        logic [W:0] trial;
        trial = {r, q[W-1]};
        if (trial >= {1'b0, d})
            return {W'(trial - {1'b0, d}), q[W-2:0], 1'b1};
        else
            return {trial[W-1:0], q[W-2:0], 1'b0};
    endfunction

    // The first bit is resolved on the start edge so the last lands W cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            quo_q    <= '0;
            den_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {rem_q, quo_q} <= div_step('0, numerator, denominator);
                den_q          <= denominator;
                cnt_q          <= CW'(W - 1);
                active_q       <= 1'b1;
            end else if (active_q) begin
                {rem_q, quo_q} <= div_step(rem_q, quo_q, den_q);
                cnt_q          <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    active_q <= 1'b0;
                    done     <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/perim_area_roi.sv
// Per-frame edge/mask pixel counts, mask bounding box and area*SCALE/perimeter ratio inside an ROI.
module perim_area_roi
    import perim_area_pkg::*;
#(
    parameter int unsigned H_ACT = DEF_H_ACT,
    parameter int unsigned V_ACT = DEF_V_ACT,
    parameter int unsigned X_W   = DEF_X_W,
    parameter int unsigned Y_W   = DEF_Y_W,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned SCALE = DEF_SCALE,
    parameter int unsigned NUM_W = CNT_W + 8
) (
    input  logic clk,
    input  logic rst_n,
    perim_area_roi_if.slave bus
);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACT - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACT - 1);

    logic [X_W-1:0]   x_q, rx0_q, rx1_q, ex, ex0, ex1;
    logic [Y_W-1:0]   y_q, ry0_q, ry1_q, ey, ey0, ey1;
    logic [CNT_W-1:0] per_q, area_q, per_nxt, area_nxt, snap_per, snap_area;
    logic [X_W-1:0]   bxmin_q, bxmax_q, bxmin_nxt, bxmax_nxt, snap_xmin, snap_xmax;
    logic [Y_W-1:0]   bymin_q, bymax_q, bymin_nxt, bymax_nxt, snap_ymin, snap_ymax;
    logic             roi_ok, in_roi, frame_end;

    state_t           state_q;
    logic             publish, div_start, div_done;
    logic [CNT_W-1:0] ratio_nxt;
    logic [NUM_W-1:0] div_num, div_den, div_quot, div_rem_unused;

    logic [CNT_W-1:0] perimeter_q, area_out_q, ratio_q;
    logic [X_W-1:0]   xmin_q, xmax_q;
    logic [Y_W-1:0]   ymin_q, ymax_q;
    logic             obj_q, dz_q, res_vld_q, busy_q, overrun_q;

    // sof acts before a same-cycle pixel: that pixel sees position (0,0), fresh ROI and empty accumulators.
    always_comb begin
        ex  = bus.sof ? '0 : x_q;
        ey  = bus.sof ? '0 : y_q;
        ex0 = bus.sof ? bus.roi_x0 : rx0_q;
        ex1 = bus.sof ? bus.roi_x1 : rx1_q;
        ey0 = bus.sof ? bus.roi_y0 : ry0_q;
        ey1 = bus.sof ? bus.roi_y1 : ry1_q;

        roi_ok    = (ex0 <= ex1) && (ey0 <= ey1) && (ex1 <= X_LAST) && (ey1 <= Y_LAST);
        in_roi    = bus.pix_vld && roi_ok && (ex >= ex0) && (ex <= ex1) && (ey >= ey0) && (ey <= ey1);
        frame_end = bus.pix_vld && (roi_ok ? ((ex == ex1) && (ey == ey1))
                                           : ((ex == X_LAST) && (ey == Y_LAST)));

        per_nxt   = bus.sof ? '0 : per_q;
        area_nxt  = bus.sof ? '0 : area_q;
        bxmin_nxt = bus.sof ? '1 : bxmin_q;
        bxmax_nxt = bus.sof ? '0 : bxmax_q;
        bymin_nxt = bus.sof ? '1 : bymin_q;
        bymax_nxt = bus.sof ? '0 : bymax_q;

        if (in_roi && bus.edge_bit)
            per_nxt = CNT_W'(sat_inc(32'(per_nxt), CNT_W));
        if (in_roi && bus.mask_bit) begin
            area_nxt = CNT_W'(sat_inc(32'(area_nxt), CNT_W));
            if (ex < bxmin_nxt) bxmin_nxt = ex;
            if (ex > bxmax_nxt) bxmax_nxt = ex;
            if (ey < bymin_nxt) bymin_nxt = ey;
            if (ey > bymax_nxt) bymax_nxt = ey;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;  y_q <= '0;
            rx0_q <= '0; rx1_q <= '0; ry0_q <= '0; ry1_q <= '0;
            per_q <= '0; area_q <= '0;
            bxmin_q <= '1; bxmax_q <= '0; bymin_q <= '1; bymax_q <= '0;
            snap_per <= '0; snap_area <= '0;
            snap_xmin <= '0; snap_xmax <= '0; snap_ymin <= '0; snap_ymax <= '0;
        end else begin
            if (bus.sof) begin
                rx0_q <= bus.roi_x0;
                rx1_q <= bus.roi_x1;
                ry0_q <= bus.roi_y0;
                ry1_q <= bus.roi_y1;
            end

            if (bus.pix_vld) begin
                if (ex == X_LAST) begin
                    x_q <= '0;
                    y_q <= (ey == Y_LAST) ? '0 : ey + 1'b1;
                end else begin
                    x_q <= ex + 1'b1;
                    y_q <= ey;
                end
            end else if (bus.sof) begin
                x_q <= '0;
                y_q <= '0;
            end

            if (frame_end) begin
                per_q <= '0; area_q <= '0;
                bxmin_q <= '1; bxmax_q <= '0; bymin_q <= '1; bymax_q <= '0;
            end else begin
                per_q <= per_nxt; area_q <= area_nxt;
                bxmin_q <= bxmin_nxt; bxmax_q <= bxmax_nxt;
                bymin_q <= bymin_nxt; bymax_q <= bymax_nxt;
            end

            if (frame_end && (state_q == IDLE)) begin
                snap_per  <= per_nxt;
                snap_area <= area_nxt;
                snap_xmin <= bxmin_nxt;
                snap_xmax <= bxmax_nxt;
                snap_ymin <= bymin_nxt;
                snap_ymax <= bymax_nxt;
            end
        end
    end

    assign div_start = (state_q == LOAD) && (snap_per != '0);
    assign div_num   = NUM_W'(snap_area) * NUM_W'(SCALE);
    assign div_den   = NUM_W'(snap_per);

    seq_divider #(.W(NUM_W)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (div_start),
        .numerator   (div_num),
        .denominator (div_den),
        .quotient    (div_quot),
        .remainder   (div_rem_unused),
        .done        (div_done)
    );

    always_comb begin
        publish   = ((state_q == LOAD) && (snap_per == '0)) || ((state_q == DIV) && div_done);
        ratio_nxt = '1;
        if ((state_q == DIV) && (div_quot[NUM_W-1:CNT_W] == '0))
            ratio_nxt = div_quot[CNT_W-1:0];
    end

    // Results are registered on entry to DONE so res_vld is visible during the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            perimeter_q <= '0; area_out_q <= '0; ratio_q <= '0;
            xmin_q <= '0; xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
            obj_q <= 1'b0; dz_q <= 1'b0;
            res_vld_q <= 1'b0; busy_q <= 1'b0; overrun_q <= 1'b0;
        end else begin
            res_vld_q <= 1'b0;
            overrun_q <= frame_end && (state_q != IDLE);

            case (state_q)
                IDLE: if (frame_end) state_q <= LOAD;
                LOAD: begin
                    if (snap_per == '0) begin
                        state_q <= DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (publish) begin
                res_vld_q   <= 1'b1;
                perimeter_q <= snap_per;
                area_out_q  <= snap_area;
                ratio_q     <= ratio_nxt;
                dz_q        <= (state_q == LOAD);
                obj_q       <= (snap_area != '0);
                xmin_q      <= (snap_area != '0) ? snap_xmin : '0;
                xmax_q      <= (snap_area != '0) ? snap_xmax : '0;
                ymin_q      <= (snap_area != '0) ? snap_ymin : '0;
                ymax_q      <= (snap_area != '0) ? snap_ymax : '0;
            end
        end
    end

    assign bus.perimeter   = perimeter_q;
    assign bus.area        = area_out_q;
    assign bus.ratio       = ratio_q;
    assign bus.bbox_xmin   = xmin_q;
    assign bus.bbox_xmax   = xmax_q;
    assign bus.bbox_ymin   = ymin_q;
    assign bus.bbox_ymax   = ymax_q;
    assign bus.obj_present = obj_q;
    assign bus.div_zero    = dz_q;
    assign bus.res_vld     = res_vld_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_perim_area_roi.sv
// Scoreboard bench for perim_area_roi on an 8x6 frame with a behavioural per-pixel model.
module tb_perim_area_roi;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int XW = 12;
    localparam int YW = 12;
    localparam int CW = 24;
    localparam int SC = 10;
    localparam int NW = CW + 8;

    typedef struct {
        longint per, area, ratio, xmin, xmax, ymin, ymax;
        bit     obj, dz;
        int     t_end, lat, busy_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    perim_area_roi_if #(.X_W(XW), .Y_W(YW), .CNT_W(CW)) bus ();

    perim_area_roi #(
        .H_ACT(H), .V_ACT(V), .X_W(XW), .Y_W(YW), .CNT_W(CW), .SCALE(SC), .NUM_W(NW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0;
    int   busy_cnt = 0, ovr_cnt = 0, exp_ovr = 0;
    int   mx, my, lx0, lx1, ly0, ly1;
    int   m_per, m_area, m_xmin, m_xmax, m_ymin, m_ymax;
    int   busy_end = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.overrun) ovr_cnt++;
            if (bus.res_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_res_vld", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("perimeter", bus.perimeter, e.per);
                    check("area", bus.area, e.area);
                    check("ratio", bus.ratio, e.ratio);
                    check("bbox_xmin", bus.bbox_xmin, e.xmin);
                    check("bbox_xmax", bus.bbox_xmax, e.xmax);
                    check("bbox_ymin", bus.bbox_ymin, e.ymin);
                    check("bbox_ymax", bus.bbox_ymax, e.ymax);
                    check("obj_present", bus.obj_present, e.obj);
                    check("div_zero", bus.div_zero, e.dz);
                    check("res_latency", cyc - e.t_end, e.lat);
                    check("busy_cycles", busy_cnt, e.busy_n);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_per = 0; m_area = 0;
        m_xmin = 1 << 30; m_xmax = -1; m_ymin = 1 << 30; m_ymax = -1;
    endtask

    task automatic model_sof();
        mx = 0; my = 0;
        lx0 = int'(bus.roi_x0); lx1 = int'(bus.roi_x1);
        ly0 = int'(bus.roi_y0); ly1 = int'(bus.roi_y1);
        model_clear();
    endtask

    task automatic model_pixel(input bit s, input bit e, input bit m);
        bit   ok, inr, fe;
        exp_t x;
        longint q;
        if (s) model_sof();
        ok  = (lx0 <= lx1) && (ly0 <= ly1) && (lx1 < H) && (ly1 < V);
        inr = ok && (mx >= lx0) && (mx <= lx1) && (my >= ly0) && (my <= ly1);
        if (inr && e) m_per++;
        if (inr && m) begin
            m_area++;
            if (mx < m_xmin) m_xmin = mx;
            if (mx > m_xmax) m_xmax = mx;
            if (my < m_ymin) m_ymin = my;
            if (my > m_ymax) m_ymax = my;
        end
        fe = ok ? ((mx == lx1) && (my == ly1)) : ((mx == H - 1) && (my == V - 1));
        if (fe) begin
            x.per  = m_per;
            x.area = m_area;
            x.dz   = (m_per == 0);
            q      = x.dz ? 0 : (longint'(m_area) * SC) / m_per;
            x.ratio = (x.dz || q > 64'hFF_FFFF) ? 64'hFF_FFFF : q;
            x.obj  = (m_area != 0);
            x.xmin = x.obj ? m_xmin : 0;
            x.xmax = x.obj ? m_xmax : 0;
            x.ymin = x.obj ? m_ymin : 0;
            x.ymax = x.obj ? m_ymax : 0;
            x.t_end  = cyc;
            x.lat    = x.dz ? 2 : NW + 2;
            x.busy_n = x.dz ? 0 : NW;
            if (cyc > busy_end) begin
                exp_q.push_back(x);
                busy_end = cyc + x.lat;
            end else begin
                exp_ovr++;
            end
            model_clear();
        end
        if (mx == H - 1) begin
            mx = 0;
            my = (my == V - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    task automatic drive(input bit s, input bit pv, input bit e, input bit m);
        tick();
        bus.sof = s; bus.pix_vld = pv; bus.edge_bit = e; bus.mask_bit = m;
        if (pv) model_pixel(s, e, m);
        else if (s) model_sof();
    endtask

    task automatic set_roi(input int x0, input int x1, input int y0, input int y1);
        bus.roi_x0 = XW'(x0); bus.roi_x1 = XW'(x1);
        bus.roi_y0 = YW'(y0); bus.roi_y1 = YW'(y1);
    endtask

    // kind 0: full ROI mask with edge ring, 1: five mask pixels, 2: only outside set, 3: random, 4: all set
    task automatic pat(input int kind, input int x, input int y, output bit e, output bit m);
        bit in_a;
        in_a = (x >= 2) && (x <= 5) && (y >= 1) && (y <= 4);
        case (kind)
            0: begin m = in_a; e = in_a && (x == 2 || x == 5 || y == 1 || y == 4); end
            1: begin m = in_a && (y == 1 || (y == 2 && x == 2)); e = 1'b0; end
            2: begin m = !in_a; e = !in_a; end
            3: begin m = 1'($urandom); e = 1'($urandom); end
            default: begin m = 1'b1; e = 1'b1; end
        endcase
    endtask

    task automatic send_frame(input int kind, input int npix, input bit sof_pix);
        bit e, m;
        if (!sof_pix) drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < npix; i++) begin
            pat(kind, i % H, i / H, e, m);
            drive(sof_pix && (i == 0), 1'b1, e, m);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check("drain_pending", exp_q.size(), 0);
        repeat (2) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e, m;
        bus.sof = 1'b0; bus.pix_vld = 1'b0; bus.edge_bit = 1'b0; bus.mask_bit = 1'b0;
        set_roi(0, 0, 0, 0);
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_perimeter", bus.perimeter, 0);
        check("rst_area", bus.area, 0);
        check("rst_ratio", bus.ratio, 0);
        check("rst_res_vld", bus.res_vld, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_obj", bus.obj_present, 0);
        check("rst_div_zero", bus.div_zero, 0);
        check("rst_bbox_xmax", bus.bbox_xmax, 0);
        rst_n = 1'b1;

        set_roi(2, 5, 1, 4);
        send_frame(0, H * V, 1'b0); drain();
        send_frame(1, H * V, 1'b0); drain();
        send_frame(2, H * V, 1'b0); drain();

        send_frame(0, 20, 1'b0);
        send_frame(0, H * V, 1'b1); drain();

        set_roi(2, 5, 1, 4);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < H * V; i++) begin
            if (i == 10) set_roi(0, 7, 0, 5);
            pat(3, i % H, i / H, e, m);
            drive(1'b0, 1'b1, e, m);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(3, H * V, 1'b0); drain();

        set_roi(5, 2, 1, 4);
        send_frame(3, H * V, 1'b0);
        set_roi(0, 8, 0, 5);
        send_frame(3, H * V, 1'b0); drain();

        set_roi(2, 5, 1, 4);
        send_frame(0, 42, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        busy_end = -1;
        #2;
        check("divrst_perimeter", bus.perimeter, 0);
        check("divrst_ratio", bus.ratio, 0);
        check("divrst_busy", bus.busy, 0);
        check("divrst_obj", bus.obj_present, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        send_frame(0, H * V, 1'b0); drain();

        set_roi(0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        set_roi(1, 1, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        for (int k = 0; k < 3; k++) begin
            int x0, y0;
            x0 = int'($urandom_range(0, H - 1));
            y0 = int'($urandom_range(0, V - 1));
            set_roi(x0, int'($urandom_range(x0, H - 1)), y0, int'($urandom_range(y0, V - 1)));
            send_frame(3, H * V, 1'b0); drain();
        end

        check("overrun_count", ovr_cnt, exp_ovr);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
